param_bus_datapath: RTL and testbench
=====================================

# param_bus_datapath

Parametrised successor to the single-bus CPU datapath. It holds an NREGS x WIDTH general register file plus PC, IR, Y, HI, LO, 64-bit Z, MAR, MDR and InPort on one shared bus. It adds priority bus arbitration with conflict detection and an MDR memory-handshake engine with wait states and timeout. The ALU stays external: it sees `y_val` and `bus`, and returns `alu_result` into Z.

## Interface
- WIDTH, 32: datapath/bus width.
- NREGS, 16: general registers, 2..32.
- ADDR_W, 9: MAR / memory address width (MAR low bits).
- MEM_TIMEOUT, 15: max wait cycles for `mem_ack`.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- reg_out  in  NREGS  per-register bus drive enables.
- reg_in  in  NREGS  per-register load enables.
- ba_out  in  1  R0 reads as zero on bus while high.
- pc_out, hi_out, lo_out, zhi_out, zlo_out, mdr_out, inport_out  in  1 each  bus drive enables.
- pc_in, ir_in, y_in, hi_in, lo_in, mar_in, mdr_in, z_in, inport_in  in  1 each  load enables.
- inc_pc  in  1  PC <= PC + 1.
- inport_data  in  WIDTH  external input port value.
- alu_result  in  2*WIDTH  ALU output, loaded into Z.
- mem_rd, mem_wr  in  1  start memory read/write.
- mem_ack  in  1  memory completion strobe.
- mem_rdata  in  WIDTH  read data, valid with `mem_ack`.
- mem_req  out  1  access in progress.
- mem_we  out  1  high during write access.
- mem_addr  out  ADDR_W  MAR[ADDR_W-1:0].
- mem_wdata  out  WIDTH  MDR value.
- mem_err  out  1  sticky timeout flag.
- busy  out  1  memory engine not IDLE.
- bus  out  WIDTH  current bus value.
- bus_conflict  out  1  more than one source enabled.
- y_val, ir_val, pc_val, mdr_val  out  WIDTH  register contents.
- z_val  out  2*WIDTH  Z contents.

## Operation
- Bus is combinational. Source priority, highest first: R0..R(NREGS-1), HI, LO, Zhigh, Zlow, PC, MDR, InPort. The highest-priority asserted source drives the bus.
- With no source asserted, bus = 0.
- `bus_conflict` = 1 whenever two or more drive enables are high, including `ba_out`-masked R0.
- R0 drives 0 when `ba_out` = 1. The stored R0 value is unaffected.
- Register loads on the clk edge take the bus value; Z takes `alu_result`; InPort takes `inport_data`.
- A single bus value may load any number of destinations in the same cycle.
- PC: `pc_in` loads the bus and has priority over `inc_pc`. `inc_pc` alone increments PC, wrapping 2^WIDTH-1 -> 0.
- Memory FSM has states IDLE, RD, WR.
  - IDLE: `mem_rd` -> RD; else `mem_wr` -> WR. Read wins if both are high. Accepting a command clears `mem_err` and the wait counter.
  - RD/WR: `mem_req` = 1 and `mem_addr` = MAR. In WR, `mem_we` = 1 and `mem_wdata` = MDR.
  - In RD, `mem_ack` loads MDR <= `mem_rdata` and returns to IDLE. In WR, `mem_ack` returns to IDLE.
  - The wait counter increments each RD/WR cycle without ack. When it reaches MEM_TIMEOUT, the FSM returns to IDLE, sets `mem_err`, and leaves MDR unchanged.
- Commands while `busy` are ignored.
- `mdr_in` while `busy` is ignored. MDR is never loaded from the bus during an access.
- `mem_ack` in IDLE is ignored.

## Timing
- All state changes happen on the rising clk edge. Reset acts immediately, independent of clk.
- Reset values: every register = 0, FSM = IDLE, `mem_req`/`mem_we`/`busy`/`mem_err` = 0. Bus and `bus_conflict` follow from zero enables.
- Register load latency: 1 cycle; the value is visible the cycle after the enable.
- Memory: a command sampled at edge N drives `mem_req` high after N. `mem_ack` sampled at edge N+k updates MDR and drops `mem_req` after N+k. Minimum access is 2 cycles, command to MDR valid.
- Timeout: with no ack, `mem_req` falls and `mem_err` rises after the MEM_TIMEOUT-th wait edge.
- Reset mid-access aborts immediately: `mem_req` = 0 and MDR = 0.

## Test plan
- Reset, then `reg_in[3]` with `inport_out` and inport_data = 0xDEADBEEF, then `reg_out[3]` -> bus = 0xDEADBEEF, `bus_conflict` = 0.
- R0 = 5, `reg_out[0]` + `ba_out` -> bus = 0. `reg_out[0]` + `pc_out` together -> bus = R0 value, `bus_conflict` = 1.
- PC = 0xFFFFFFFF, `inc_pc` -> PC = 0. `pc_in` + `inc_pc` with bus = 0x10 -> PC = 0x10.
- MAR = 0x1A3, `mem_rd`, ack after 3 wait cycles with rdata 0x12345678 -> `mem_addr` = 0x1A3 while `mem_req` is high, MDR = 0x12345678. `mdr_in` during the wait is ignored.
- `mem_wr` with MDR = 0xCAFE and no ack -> `mem_we` = 1 and `mem_wdata` = 0xCAFE for 15 cycles, then `mem_req` = 0 and `mem_err` = 1. The next `mem_rd` clears `mem_err`.
- Assert reset during RD -> `mem_req`, `busy`, MDR and all registers read 0 immediately. After release, the FSM accepts a new command.

Source files
------------

// File: rtl/param_bus_datapath.sv
// Single-bus CPU datapath: NREGS x WIDTH register file, special registers,
// priority bus arbitration with conflict flag, and an MDR memory handshake engine.
module param_bus_datapath #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned NREGS       = 16,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREGS-1:0]     reg_out,
    input  logic [NREGS-1:0]     reg_in,
    input  logic                 ba_out,
    input  logic                 pc_out,
    input  logic                 hi_out,
    input  logic                 lo_out,
    input  logic                 zhi_out,
    input  logic                 zlo_out,
    input  logic                 mdr_out,
    input  logic                 inport_out,
    input  logic                 pc_in,
    input  logic                 ir_in,
    input  logic                 y_in,
    input  logic                 hi_in,
    input  logic                 lo_in,
    input  logic                 mar_in,
    input  logic                 mdr_in,
    input  logic                 z_in,
    input  logic                 inport_in,
    input  logic                 inc_pc,
    input  logic [WIDTH-1:0]     inport_data,
    input  logic [2*WIDTH-1:0]   alu_result,
    input  logic                 mem_rd,
    input  logic                 mem_wr,
    input  logic                 mem_ack,
    input  logic [WIDTH-1:0]     mem_rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 mem_err,
    output logic                 busy,
    output logic [WIDTH-1:0]     bus,
    output logic                 bus_conflict,
    output logic [WIDTH-1:0]     y_val,
    output logic [WIDTH-1:0]     ir_val,
    output logic [WIDTH-1:0]     pc_val,
    output logic [WIDTH-1:0]     mdr_val,
    output logic [2*WIDTH-1:0]   z_val
);
    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned NSRC  = NREGS + 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } mem_state_e;

    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   regs_d [NREGS];
    logic [WIDTH-1:0]   pc_q, pc_d, ir_q, ir_d, y_q, y_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   mdr_q, mdr_d, inport_q, inport_d;
    logic [ADDR_W-1:0]  mar_q, mar_d;
    logic [2*WIDTH-1:0] z_q, z_d;
    mem_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               req_q, req_d, we_q, we_d, err_q, err_d;
    logic [NSRC-1:0]    src_en;

    // Bus mux: lowest priority assigned first so higher-priority sources override.
    always_comb begin
        bus = '0;
        if (inport_out) bus = inport_q;
        if (mdr_out)    bus = mdr_q;
        if (pc_out)     bus = pc_q;
        if (zlo_out)    bus = z_q[WIDTH-1:0];
        if (zhi_out)    bus = z_q[2*WIDTH-1:WIDTH];
        if (lo_out)     bus = lo_q;
        if (hi_out)     bus = hi_q;
        for (int i = int'(NREGS) - 1; i >= 0; i--) begin
            if (reg_out[i]) bus = (i == 0 && ba_out) ? '0 : regs_q[i];
        end
    end

    assign src_en       = {reg_out, hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out};
    assign bus_conflict = ($countones(src_en) > 1);

    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) begin
            regs_d[i] = reg_in[i] ? bus : regs_q[i];
        end
        ir_d     = ir_in ? bus : ir_q;
        y_d      = y_in  ? bus : y_q;
        hi_d     = hi_in ? bus : hi_q;
        lo_d     = lo_in ? bus : lo_q;
        mar_d    = mar_in ? bus[ADDR_W-1:0] : mar_q;
        z_d      = z_in ? alu_result : z_q;
        inport_d = inport_in ? inport_data : inport_q;
        if (pc_in)       pc_d = bus;
        else if (inc_pc) pc_d = pc_q + WIDTH'(1);
        else             pc_d = pc_q;
    end

    // Memory engine; MDR takes the bus only while idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        req_d   = 1'b0;
        we_d    = 1'b0;
        mdr_d   = (mdr_in && state_q == ST_IDLE) ? bus : mdr_q;
        cnt_inc = cnt_q + CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (mem_rd) begin
                    state_d = ST_RD;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    req_d   = 1'b1;
                end else if (mem_wr) begin
                    state_d = ST_WR;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                end
            end
            ST_RD, ST_WR: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                    if (state_q == ST_RD) mdr_d = mem_rdata;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(MEM_TIMEOUT)) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        req_d = 1'b1;
                        we_d  = (state_q == ST_WR);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q   <= '{default: '0};
            pc_q     <= '0;
            ir_q     <= '0;
            y_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mar_q    <= '0;
            mdr_q    <= '0;
            z_q      <= '0;
            inport_q <= '0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            y_q      <= y_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            z_q      <= z_d;
            inport_q <= inport_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            err_q    <= err_d;
        end
    end

    assign mem_req   = req_q;
    assign busy      = req_q;
    assign mem_we    = we_q;
    assign mem_err   = err_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;
    assign y_val     = y_q;
    assign ir_val    = ir_q;
    assign pc_val    = pc_q;
    assign mdr_val   = mdr_q;
    assign z_val     = z_q;

endmodule

// File: tb/tb_param_bus_datapath.sv
// Randomized + directed bench for param_bus_datapath; a reference model predicts
// each cycle's observable state into a queue that a negedge monitor drains.
module tb_param_bus_datapath;
    localparam int W  = 32;
    localparam int N  = 16;
    localparam int AW = 9;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0] reg_out, reg_in;
    logic ba_out, pc_out, hi_out, lo_out, zhi_out, zlo_out, mdr_out, inport_out;
    logic pc_in, ir_in, y_in, hi_in, lo_in, mar_in, mdr_in, z_in, inport_in, inc_pc;
    logic [W-1:0] inport_data, mem_rdata;
    logic [2*W-1:0] alu_result;
    logic mem_rd, mem_wr, mem_ack;
    logic mem_req, mem_we, mem_err, busy, bus_conflict;
    logic [AW-1:0] mem_addr;
    logic [W-1:0] mem_wdata, bus, y_val, ir_val, pc_val, mdr_val;
    logic [2*W-1:0] z_val;

    param_bus_datapath #(.WIDTH(W), .NREGS(N), .ADDR_W(AW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .reg_out(reg_out), .reg_in(reg_in), .ba_out(ba_out),
        .pc_out(pc_out), .hi_out(hi_out), .lo_out(lo_out), .zhi_out(zhi_out), .zlo_out(zlo_out),
        .mdr_out(mdr_out), .inport_out(inport_out), .pc_in(pc_in), .ir_in(ir_in), .y_in(y_in),
        .hi_in(hi_in), .lo_in(lo_in), .mar_in(mar_in), .mdr_in(mdr_in), .z_in(z_in),
        .inport_in(inport_in), .inc_pc(inc_pc), .inport_data(inport_data), .alu_result(alu_result),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_err(mem_err), .busy(busy), .bus(bus), .bus_conflict(bus_conflict),
        .y_val(y_val), .ir_val(ir_val), .pc_val(pc_val), .mdr_val(mdr_val), .z_val(z_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] reg_out, reg_in;
        logic ba_out, pc_out, hi_out, lo_out, zhi_out, zlo_out, mdr_out, inport_out;
        logic pc_in, ir_in, y_in, hi_in, lo_in, mar_in, mdr_in, z_in, inport_in, inc_pc;
        logic [W-1:0] inport_data, mem_rdata;
        logic [2*W-1:0] alu_result;
        logic mem_rd, mem_wr, mem_ack;
    } stim_t;

    typedef struct {
        logic [W-1:0] bus, pc, y, ir, mdr;
        logic [2*W-1:0] z;
        logic conflict, req, we, err, busy;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] m_r [N];
    logic [W-1:0] m_pc, m_ir, m_y, m_hi, m_lo, m_mdr, m_in;
    logic [2*W-1:0] m_z;
    logic [AW-1:0] m_mar;
    bit m_active, m_wr, m_err;
    int m_left;

    function automatic stim_t idle_s();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // First enabled source in priority order wins.
    function automatic logic [W-1:0] model_bus(stim_t s);
        for (int i = 0; i < N; i++)
            if (s.reg_out[i]) return (i == 0 && s.ba_out) ? '0 : m_r[i];
        if (s.hi_out) return m_hi;
        if (s.lo_out) return m_lo;
        if (s.zhi_out) return m_z[2*W-1:W];
        if (s.zlo_out) return m_z[W-1:0];
        if (s.pc_out) return m_pc;
        if (s.mdr_out) return m_mdr;
        if (s.inport_out) return m_in;
        return '0;
    endfunction

    function automatic int n_enabled(stim_t s);
        int n = $countones(s.reg_out);
        n += int'(s.hi_out) + int'(s.lo_out) + int'(s.zhi_out) + int'(s.zlo_out);
        n += int'(s.pc_out) + int'(s.mdr_out) + int'(s.inport_out);
        return n;
    endfunction

    function automatic exp_t model_outputs(stim_t s);
        exp_t e;
        e.bus = model_bus(s);
        e.conflict = (n_enabled(s) > 1);
        e.pc = m_pc; e.y = m_y; e.ir = m_ir; e.mdr = m_mdr; e.z = m_z;
        e.req = m_active; e.busy = m_active; e.we = m_active && m_wr;
        e.err = m_err; e.addr = m_mar;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_r[i] = '0;
        m_pc = '0; m_ir = '0; m_y = '0; m_hi = '0; m_lo = '0; m_mdr = '0; m_in = '0;
        m_z = '0; m_mar = '0; m_active = 0; m_wr = 0; m_err = 0; m_left = 0;
    endtask

    task automatic model_step(stim_t s);
        logic [W-1:0] b;
        b = model_bus(s);
        for (int i = 0; i < N; i++) if (s.reg_in[i]) m_r[i] = b;
        if (s.hi_in) m_hi = b;
        if (s.lo_in) m_lo = b;
        if (s.y_in) m_y = b;
        if (s.ir_in) m_ir = b;
        if (s.mar_in) m_mar = b[AW-1:0];
        if (s.z_in) m_z = s.alu_result;
        if (s.inport_in) m_in = s.inport_data;
        if (s.pc_in) m_pc = b;
        else if (s.inc_pc) m_pc = m_pc + 1;
        if (!m_active) begin
            if (s.mdr_in) m_mdr = b;
            if (s.mem_rd || s.mem_wr) begin
                m_active = 1; m_wr = !s.mem_rd; m_left = TO; m_err = 0;
            end
        end else if (s.mem_ack) begin
            if (!m_wr) m_mdr = s.mem_rdata;
            m_active = 0;
        end else begin
            m_left--;
            if (m_left == 0) begin m_active = 0; m_err = 1; end
        end
    endtask

    task automatic apply(stim_t s);
        reg_out = s.reg_out; reg_in = s.reg_in; ba_out = s.ba_out;
        pc_out = s.pc_out; hi_out = s.hi_out; lo_out = s.lo_out; zhi_out = s.zhi_out;
        zlo_out = s.zlo_out; mdr_out = s.mdr_out; inport_out = s.inport_out;
        pc_in = s.pc_in; ir_in = s.ir_in; y_in = s.y_in; hi_in = s.hi_in; lo_in = s.lo_in;
        mar_in = s.mar_in; mdr_in = s.mdr_in; z_in = s.z_in; inport_in = s.inport_in;
        inc_pc = s.inc_pc; inport_data = s.inport_data; alu_result = s.alu_result;
        mem_rd = s.mem_rd; mem_wr = s.mem_wr; mem_ack = s.mem_ack; mem_rdata = s.mem_rdata;
    endtask

    // Called at posedge+1: drive, predict this cycle, then advance across the edge.
    task automatic cycle(stim_t s);
        apply(s);
        sb_q.push_back(model_outputs(s));
        @(posedge clk);
        model_step(s);
        #1;
    endtask

    // Reset asserted mid-cycle; the monitor checks it before the next edge.
    task automatic do_reset();
        apply(idle_s());
        reset = 1'b0;
        model_reset();
        sb_q.push_back(model_outputs(idle_s()));
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic stim_t rand_s(int ack_div);
        stim_t s = idle_s();
        for (int i = 0; i < N; i++) begin
            s.reg_out[i] = ($urandom_range(0, 15) == 0);
            s.reg_in[i]  = ($urandom_range(0, 7) == 0);
        end
        s.ba_out = ($urandom_range(0, 2) == 0);
        s.hi_out = ($urandom_range(0, 9) == 0); s.lo_out = ($urandom_range(0, 9) == 0);
        s.zhi_out = ($urandom_range(0, 9) == 0); s.zlo_out = ($urandom_range(0, 9) == 0);
        s.pc_out = ($urandom_range(0, 9) == 0); s.mdr_out = ($urandom_range(0, 9) == 0);
        s.inport_out = ($urandom_range(0, 5) == 0);
        s.pc_in = ($urandom_range(0, 4) == 0); s.ir_in = ($urandom_range(0, 4) == 0);
        s.y_in = ($urandom_range(0, 4) == 0); s.hi_in = ($urandom_range(0, 4) == 0);
        s.lo_in = ($urandom_range(0, 4) == 0); s.mar_in = ($urandom_range(0, 4) == 0);
        s.mdr_in = ($urandom_range(0, 3) == 0); s.z_in = ($urandom_range(0, 3) == 0);
        s.inport_in = ($urandom_range(0, 2) == 0); s.inc_pc = ($urandom_range(0, 2) == 0);
        s.inport_data = $urandom;
        s.alu_result = {$urandom, $urandom};
        s.mem_rd = ($urandom_range(0, 5) == 0); s.mem_wr = ($urandom_range(0, 5) == 0);
        s.mem_ack = ($urandom_range(0, ack_div - 1) == 0);
        s.mem_rdata = $urandom;
        return s;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares the DUT against the oldest prediction at each negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("bus", 64'(bus), 64'(e.bus));
                chk("bus_conflict", 64'(bus_conflict), 64'(e.conflict));
                chk("pc_val", 64'(pc_val), 64'(e.pc));
                chk("y_val", 64'(y_val), 64'(e.y));
                chk("ir_val", 64'(ir_val), 64'(e.ir));
                chk("mdr_val", 64'(mdr_val), 64'(e.mdr));
                chk("mem_wdata", 64'(mem_wdata), 64'(e.mdr));
                chk("z_val", z_val, e.z);
                chk("mem_req", 64'(mem_req), 64'(e.req));
                chk("busy", 64'(busy), 64'(e.busy));
                chk("mem_we", 64'(mem_we), 64'(e.we));
                chk("mem_err", 64'(mem_err), 64'(e.err));
                chk("mem_addr", 64'(mem_addr), 64'(e.addr));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        stim_t s;
        reset = 1'b0;
        apply(idle_s());
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // InPort -> R3 -> bus
        s = idle_s(); s.inport_in = 1; s.inport_data = 32'hDEADBEEF; cycle(s);
        s = idle_s(); s.inport_out = 1; s.reg_in[3] = 1; cycle(s);
        s = idle_s(); s.reg_out[3] = 1; cycle(s);
        // R0 masking and conflict
        s = idle_s(); s.inport_in = 1; s.inport_data = 32'd5; cycle(s);
        s = idle_s(); s.inport_out = 1; s.reg_in[0] = 1; cycle(s);
        s = idle_s(); s.reg_out[0] = 1; s.ba_out = 1; cycle(s);
        s = idle_s(); s.reg_out[0] = 1; s.pc_out = 1; cycle(s);
        // PC wrap and pc_in priority
        s = idle_s(); s.inport_in = 1; s.inport_data = 32'hFFFFFFFF; cycle(s);
        s = idle_s(); s.inport_out = 1; s.pc_in = 1; cycle(s);
        s = idle_s(); s.inc_pc = 1; cycle(s);
        s = idle_s(); s.inport_in = 1; s.inport_data = 32'h10; cycle(s);
        s = idle_s(); s.inport_out = 1; s.pc_in = 1; s.inc_pc = 1; cycle(s);
        cycle(idle_s());
        // Read with wait states; mdr_in during the access is dropped
        s = idle_s(); s.inport_in = 1; s.inport_data = 32'h1A3; cycle(s);
        s = idle_s(); s.inport_out = 1; s.mar_in = 1; cycle(s);
        s = idle_s(); s.mem_rd = 1; cycle(s);
        cycle(idle_s());
        s = idle_s(); s.inport_out = 1; s.mdr_in = 1; cycle(s);
        cycle(idle_s());
        s = idle_s(); s.mem_ack = 1; s.mem_rdata = 32'h12345678; cycle(s);
        cycle(idle_s());
        // Write with timeout, then a read clears the error
        s = idle_s(); s.inport_in = 1; s.inport_data = 32'hCAFE; cycle(s);
        s = idle_s(); s.inport_out = 1; s.mdr_in = 1; cycle(s);
        s = idle_s(); s.mem_wr = 1; cycle(s);
        repeat (17) cycle(idle_s());
        s = idle_s(); s.mem_rd = 1; cycle(s);
        s = idle_s(); s.mem_ack = 1; s.mem_rdata = 32'hA5A5_0001; cycle(s);
        cycle(idle_s());
        // Reset in the middle of a read, then a fresh access
        s = idle_s(); s.mem_rd = 1; cycle(s);
        cycle(idle_s());
        do_reset();
        s = idle_s(); s.reg_out[3] = 1; s.mem_rd = 1; cycle(s);
        s = idle_s(); s.mem_ack = 1; s.mem_rdata = 32'h0BAD_F00D; cycle(s);
        cycle(idle_s());

        // Random traffic, alternating quick-ack and slow-ack phases
        for (int blk = 0; blk < 6; blk++) begin
            for (int c = 0; c < 100; c++) cycle(rand_s((blk % 2 == 0) ? 3 : 40));
            if (blk == 2) do_reset();
        end

        cycle(idle_s());
        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
